// File: rtl/vector_mem_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_mem_sequencer_if : command and data-memory bus of the sequencer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface vector_mem_sequencer_if #(
    parameter int LANES        = 4,
    parameter int MAX_STRIDE_W = 10
);
    logic                    start;
    logic                    isStore;
    logic [31:0]             baseAddr;
    logic [MAX_STRIDE_W-1:0] stride;
    logic [LANES-1:0]        laneMask;
    logic [LANES*32-1:0]     storeData;
    logic                    busy;
    logic                    done;
    logic [LANES*32-1:0]     loadData;
    logic                    memWriteEnable;
    logic [31:0]             memAddress;
    logic [31:0]             memWriteData;
    logic [31:0]             memReadData;

    modport master (
        output start, isStore, baseAddr, stride, laneMask, storeData, memReadData,
        input  busy, done, loadData, memWriteEnable, memAddress, memWriteData
    );

    modport slave (
        input  start, isStore, baseAddr, stride, laneMask, storeData, memReadData,
        output busy, done, loadData, memWriteEnable, memAddress, memWriteData
    );
endinterface
`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_mem_sequencer : strided, masked vector load/store, one lane/cycle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vector_mem_sequencer #(
    parameter int LANES        = 4,
    parameter int MAX_STRIDE_W = 10
) (
    input  wire logic               clk,
    input  wire logic               rst,
    vector_mem_sequencer_if.slave   bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [LANE_W-1:0]       r_lane;
    logic                    r_is_store;
    logic [MAX_STRIDE_W-1:0] r_stride;
    logic [LANES-1:0]        r_mask;
    logic [LANES*32-1:0]     r_store_data;
    logic [LANES*32-1:0]     r_load_data;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;

    logic [LANE_W-1:0]       w_next_lane;
    logic [31:0]             w_next_word;
    logic                    w_next_we;

    assign w_next_lane = r_lane + 1'b1;
    assign w_next_word = r_store_data[32*w_next_lane +: 32];
    assign w_next_we   = r_is_store & r_mask[w_next_lane];

    // Memory-side outputs are registered one lane ahead so each lane's
    // address/strobe/data are stable for the whole ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_is_store   <= 1'b0;
            r_stride     <= '0;
            r_mask       <= '0;
            r_store_data <= '0;
            r_load_data  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_lane <= '0;
                    if (bus.start) begin
                        r_is_store   <= bus.isStore;
                        r_stride     <= bus.stride;
                        r_mask       <= bus.laneMask;
                        r_store_data <= bus.storeData;
                        r_addr       <= bus.baseAddr;
                        r_we         <= bus.isStore & bus.laneMask[0];
                        r_wdata      <= (bus.isStore & bus.laneMask[0]) ? bus.storeData[31:0] : 32'd0;
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end else begin
                        r_we    <= 1'b0;
                        r_addr  <= 32'd0;
                        r_wdata <= 32'd0;
                    end
                end
                ACCESS: begin
                    if (!r_is_store && r_mask[r_lane]) begin
                        r_load_data[32*r_lane +: 32] <= bus.memReadData;
                    end
                    if (r_lane == LAST_LANE) begin
                        r_we    <= 1'b0;
                        r_addr  <= 32'd0;
                        r_wdata <= 32'd0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_lane  <= w_next_lane;
                        r_addr  <= r_addr + 32'(r_stride);
                        r_we    <= w_next_we;
                        r_wdata <= w_next_we ? w_next_word : 32'd0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_lane  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= 32'd0;
                    r_wdata <= 32'd0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.loadData       = r_load_data;
    assign bus.memWriteEnable = r_we;
    assign bus.memAddress     = r_addr;
    assign bus.memWriteData   = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_mem_sequencer : directed bench with a word-addressed memory   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vector_mem_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   we_count;
    logic [31:0] mem [0:255];

    vector_mem_sequencer_if #(.LANES(4), .MAX_STRIDE_W(10)) bus ();

    vector_mem_sequencer #(.LANES(4), .MAX_STRIDE_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.memReadData = mem[bus.memAddress[7:0]];

    always @(negedge clk) begin
        if (bus.memWriteEnable) begin
            mem[bus.memAddress[7:0]] = bus.memWriteData;
            we_count = we_count + 1;
        end
    end

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one command and checks each lane's bus cycle, the done pulse
    // on cycle LANES+1 and the return to idle. glitch re-pulses start mid-run.
    task automatic run_cmd(input logic st, input logic [31:0] base, input logic [9:0] strd,
                           input logic [3:0] mask, input logic [127:0] data, input bit glitch);
        logic [31:0] exp_addr;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.isStore   = st;
        bus.baseAddr  = base;
        bus.stride    = strd;
        bus.laneMask  = mask;
        bus.storeData = data;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_addr  = base;
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("lane%0d_addr", i), {96'd0, bus.memAddress}, {96'd0, exp_addr});
            check_value($sformatf("lane%0d_we", i), {127'd0, bus.memWriteEnable}, {127'd0, st & mask[i]});
            if (st && mask[i])
                check_value($sformatf("lane%0d_wdata", i), {96'd0, bus.memWriteData}, {96'd0, data[32*i +: 32]});
            check_value($sformatf("lane%0d_busy_done", i), {126'd0, bus.busy, bus.done}, {126'd0, 2'b10});
            if (glitch && i == 1) begin
                bus.start     = 1'b1;
                bus.isStore   = ~st;
                bus.baseAddr  = 32'h0000_0000;
                bus.stride    = 10'd7;
                bus.laneMask  = 4'b1111;
                bus.storeData = {4{32'h0000_0BAD}};
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            exp_addr  = exp_addr + {22'd0, strd};
        end
        check_value("done_cycle", {126'd0, bus.busy, bus.done}, {126'd0, 2'b11});
        check_value("done_we", {127'd0, bus.memWriteEnable}, 128'd0);
        @(posedge clk); #1;
        check_value("after_done", {126'd0, bus.busy, bus.done}, 128'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; we_count = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        bus.start = 1'b0; bus.isStore = 1'b0; bus.baseAddr = 32'd0;
        bus.stride = 10'd0; bus.laneMask = 4'd0; bus.storeData = 128'd0;
        rst = 1'b1;
        #3;
        check_value("rst_busy", {127'd0, bus.busy}, 128'd0);
        check_value("rst_done", {127'd0, bus.done}, 128'd0);
        check_value("rst_we", {127'd0, bus.memWriteEnable}, 128'd0);
        check_value("rst_addr", {96'd0, bus.memAddress}, 128'd0);
        check_value("rst_wdata", {96'd0, bus.memWriteData}, 128'd0);
        check_value("rst_load", bus.loadData, 128'd0);
        @(negedge clk); rst = 1'b0;

        // Unit-stride gather
        mem[8'h10] = 32'hAAAA_0001; mem[8'h11] = 32'hBBBB_0002;
        mem[8'h12] = 32'hCCCC_0003; mem[8'h13] = 32'hDDDD_0004;
        we_count = 0;
        run_cmd(1'b0, 32'h10, 10'd1, 4'b1111, 128'd0, 1'b0);
        check_value("load1_data", bus.loadData, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);
        check_value("load1_no_write", 128'(we_count), 128'd0);

        // Stride-4 scatter; loadData must be untouched
        we_count = 0;
        run_cmd(1'b1, 32'h20, 10'd4, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        check_value("store1_m20", {96'd0, mem[8'h20]}, 128'd1);
        check_value("store1_m24", {96'd0, mem[8'h24]}, 128'd2);
        check_value("store1_m28", {96'd0, mem[8'h28]}, 128'd3);
        check_value("store1_m2c", {96'd0, mem[8'h2C]}, 128'd4);
        check_value("store1_we_cnt", 128'(we_count), 128'd4);
        check_value("store1_load_hold", bus.loadData, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);

        // Masked store 0101
        for (int k = 0; k < 4; k++) mem[8'h40 + k] = 32'hDEAD_0000 + k;
        we_count = 0;
        run_cmd(1'b1, 32'h40, 10'd1, 4'b0101, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
        check_value("mask_m40", {96'd0, mem[8'h40]}, 128'h11);
        check_value("mask_m41", {96'd0, mem[8'h41]}, 128'hDEAD_0001);
        check_value("mask_m42", {96'd0, mem[8'h42]}, 128'h33);
        check_value("mask_m43", {96'd0, mem[8'h43]}, 128'hDEAD_0003);
        check_value("mask_we_cnt", 128'(we_count), 128'd2);

        // Address wrap past 0xFFFFFFFF
        mem[8'hFF] = 32'hF0F0_0000; mem[8'h00] = 32'hF1F1_0001;
        mem[8'h01] = 32'hF2F2_0002; mem[8'h02] = 32'hF3F3_0003;
        run_cmd(1'b0, 32'hFFFF_FFFF, 10'd1, 4'b1111, 128'd0, 1'b0);
        check_value("wrap_load", bus.loadData, 128'hF3F3_0003_F2F2_0002_F1F1_0001_F0F0_0000);

        // start re-pulsed mid-command with conflicting fields is ignored
        mem[8'h80] = 32'hE000_0000; mem[8'h82] = 32'hE111_0001;
        mem[8'h84] = 32'hE222_0002; mem[8'h86] = 32'hE333_0003;
        we_count = 0;
        run_cmd(1'b0, 32'h80, 10'd2, 4'b1011, 128'd0, 1'b1);
        check_value("glitch_load", bus.loadData, 128'hE333_0003_F2F2_0002_E111_0001_E000_0000);
        check_value("glitch_no_write", 128'(we_count), 128'd0);

        // All-zero mask still runs the full sequence
        we_count = 0;
        run_cmd(1'b1, 32'h10, 10'd1, 4'b0000, {4{32'h0BAD_0BAD}}, 1'b0);
        check_value("zmask_we_cnt", 128'(we_count), 128'd0);
        check_value("zmask_m10", {96'd0, mem[8'h10]}, 128'hAAAA_0001);

        // Reset during lane 2 of a store aborts it
        for (int k = 0; k < 4; k++) mem[8'h60 + k] = 32'h5555_0000 + k;
        @(negedge clk);
        bus.start = 1'b1; bus.isStore = 1'b1; bus.baseAddr = 32'h60; bus.stride = 10'd1;
        bus.laneMask = 4'b1111; bus.storeData = {32'h64, 32'h63, 32'h62, 32'h61};
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_value("abort_busy_done", {126'd0, bus.busy, bus.done}, 128'd0);
        check_value("abort_we", {127'd0, bus.memWriteEnable}, 128'd0);
        check_value("abort_addr", {96'd0, bus.memAddress}, 128'd0);
        check_value("abort_wdata", {96'd0, bus.memWriteData}, 128'd0);
        check_value("abort_load", bus.loadData, 128'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_value("abort_no_done", {127'd0, bus.done}, 128'd0);
        end
        @(negedge clk); rst = 1'b0;
        check_value("abort_m60", {96'd0, mem[8'h60]}, 128'h61);
        check_value("abort_m61", {96'd0, mem[8'h61]}, 128'h62);
        check_value("abort_m62", {96'd0, mem[8'h62]}, 128'h5555_0002);
        check_value("abort_m63", {96'd0, mem[8'h63]}, 128'h5555_0003);

        // First command after reset is accepted normally
        run_cmd(1'b0, 32'h10, 10'd1, 4'b1111, 128'd0, 1'b0);
        check_value("post_rst_load", bus.loadData, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
